// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the fetch front end.
//   fetch_state_e    - fetch sequencer states (RUN / FLUSH)
//   RESET_PC_DEFAULT - default first fetch address after reset
//   INSTR_NOP        - canonical NOP encoding (addi x0, x0, 0)
//   word_align()     - clears the byte-offset bits of an address
package riscv_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with a show-ahead head and a flush input.
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - empties the FIFO; a push or pop in the same cycle is ignored
//   push       - write push_data (caller guarantees no overflow)
//   push_data  - WIDTH-bit write data
//   pop        - remove the head entry (ignored when empty)
//   head_data  - current head entry (valid when count != 0)
//   count      - number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_en;
    logic             pop_en;

    assign push_en = push && !flush;
    assign pop_en  = pop && !flush && (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    // Storage carries no reset; entries are only observed when count says so.
    // On a full FIFO with simultaneous push and pop, the write lands in the
    // slot being read, which still presents its old value this cycle.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues in-order requests
// to instruction memory, buffers returned words, and hands them to decode.
//   clk, rst                         - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        - request channel (word-aligned address)
//   imem_rsp_valid/data              - in-order response channel, no backpressure
//   redirect_valid/pc                - control-flow redirect (flushes, restarts)
//   if_valid/ready                   - decode handshake
//   if_instr/if_pc/if_pc_plus4       - head instruction, its address, address+4
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;

    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   tag_count;
    logic [63:0]     fifo_head;
    logic [31:0]     tag_head;
    logic [CW:0]     in_flight;

    logic            req_fire;
    logic            rsp_take;
    logic            data_push;
    logic            if_pop;

    assign if_pop = if_valid && if_ready;

    // Slots already claimed downstream. A pop in this cycle frees a slot
    // before any response to a new request can arrive (latency >= 1), so it
    // is credited here; that is what allows one instruction per cycle.
    assign in_flight = {1'b0, outstanding_reg} + {1'b0, fifo_count}
                     - (CW+1)'(if_pop);

    assign imem_req_valid = !rst && (state_reg == RUN)
                         && (in_flight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding has no matching request; ignore it.
    assign rsp_take  = imem_rsp_valid && (outstanding_reg != '0);
    // In FLUSH every response is stale. On a redirect the FIFO flush drops it.
    assign data_push = rsp_take && (state_reg == RUN) && (tag_count != '0);

    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_take);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = word_align(redirect_pc);
            state_next    = (outstanding_next != '0) ? FLUSH : RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (req_fire) begin
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end
                FLUSH: begin
                    if (outstanding_next == '0) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
        end
    end

    // PC of every accepted request, matched in order with its response.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (data_push),
        .head_data (tag_head),
        .count     (tag_count)
    );

    // {instr, pc} pairs waiting for decode.
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (data_push),
        .push_data ({imem_rsp_data, tag_head}),
        .pop       (if_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Outputs are zeroed when empty so decode never sees stale FIFO contents.
    assign if_valid    = (fifo_count != '0);
    assign if_instr    = if_valid ? fifo_head[63:32] : 32'h0;
    assign if_pc       = if_valid ? fifo_head[31:0]  : 32'h0;
    assign if_pc_plus4 = if_valid ? (fifo_head[31:0] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Directed phases push the
// expected PCs of delivered instructions; a monitor pops and compares on each
// decode handshake. A second instance checks a near-wrap RESET_PC.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        req_valid2;
    logic        req_ready2 = 1'b1;
    logic [31:0] req_addr2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        if_valid2;
    logic        if_ready2 = 1'b1;
    logic [31:0] if_instr2, if_pc2, if_pc_plus4_2;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_hi (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid2),
        .imem_req_ready (req_ready2),
        .imem_req_addr  (req_addr2),
        .imem_rsp_valid (rsp_valid2),
        .imem_rsp_data  (rsp_data2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .if_valid       (if_valid2),
        .if_ready       (if_ready2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2),
        .if_pc_plus4    (if_pc_plus4_2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;
    int req_count = 0;
    int idx2 = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t       pend[$];
    logic [31:0] exp_q[$];

    logic [31:0] exp2_pc [3];
    logic [31:0] exp2_p4 [3];
    logic        pend2 = 1'b0;
    logic [31:0] pend_addr2 = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return INSTR_NOP ^ {a[23:0], 8'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: fixed latency of 'lat' cycles after acceptance.
    always @(negedge clk) begin
        pend_t p;
        if (rst) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (pend.size() != 0 && pend[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #2;
        if (!rst && imem_req_valid && imem_req_ready) begin
            p.due  = cyc + lat;
            p.addr = imem_req_addr;
            pend.push_back(p);
            req_count++;
        end
    end

    // One-cycle memory for the high-RESET_PC instance.
    always @(negedge clk) begin
        if (rst) begin
            rsp_valid2 = 1'b0;
            rsp_data2  = 32'h0;
            pend2      = 1'b0;
        end else begin
            rsp_valid2 = pend2;
            rsp_data2  = instr_of(pend_addr2);
        end
        #2;
        pend2      = !rst && req_valid2 && req_ready2;
        pend_addr2 = req_addr2;
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (!rst && if_valid && if_ready) begin
            $display("deliver pc=%08h instr=%08h pc+4=%08h", if_pc, if_instr, if_pc_plus4);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_delivery: got pc %08h, expected no delivery", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("if_pc", if_pc, e);
                chk("if_instr", if_instr, instr_of(e));
                chk("if_pc_plus4", if_pc_plus4, e + 32'd4);
            end
        end
    end

    // Monitor for the high-RESET_PC instance: first three deliveries only.
    always @(negedge clk) begin
        #3;
        if (!rst && if_valid2 && idx2 < 3) begin
            $display("deliver_hi pc=%08h pc+4=%08h", if_pc2, if_pc_plus4_2);
            chk("hi_if_pc", if_pc2, exp2_pc[idx2]);
            chk("hi_if_pc_plus4", if_pc_plus4_2, exp2_p4[idx2]);
            chk("hi_if_instr", if_instr2, instr_of(exp2_pc[idx2]));
            idx2++;
        end
    end

    initial begin
        exp2_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        exp2_p4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        lat            = 1;
        #1 rst = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("rst_hi_req_addr", req_addr2, 32'hFFFF_FFF8);

        // Streaming: 1-cycle memory, decode always ready
        next_cycle();
        rst = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        #2;
        chk("start_req_valid", imem_req_valid, 1'b1);
        chk("start_req_addr", imem_req_addr, 32'h0);
        chk("stream_if_valid_k0", if_valid, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            #2;
            chk($sformatf("stream_if_valid_k%0d", k), if_valid, (k >= 2));
        end

        // Decode stall: throttle stops after DEPTH buffered words
        next_cycle();
        if_ready = 1'b0;
        repeat (5) next_cycle();
        #2;
        chk("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_if_valid", if_valid, 1'b1);
        chk("stall_req_count", req_count, 32'd10);
        chk("stall_head_pc", if_pc, 32'h20);

        // Release: no loss or duplication
        next_cycle();
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h20 + 32'(i * 4));
        repeat (5) next_cycle();
        next_cycle();
        if_ready = 1'b0;
        next_cycle();
        #2;
        chk("release_exp_empty", exp_q.size(), 32'd0);

        // Reset, switch to 3-cycle memory
        next_cycle();
        rst = 1'b1;
        lat = 3;
        next_cycle();
        next_cycle();

        // Redirect to 0x100 with two requests outstanding
        next_cycle();
        rst = 1'b0;
        #2;
        chk("p3_req_addr_k0", imem_req_addr, 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        exp_q.push_back(32'h100);
        #2;
        chk("p3_req_addr_k1", imem_req_addr, 32'h4);
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            redirect_valid = 1'b0;
            #2;
            chk($sformatf("flush_req_valid_k%0d", k), imem_req_valid, 1'b0);
        end
        next_cycle();
        #2;
        chk("target_req_valid", imem_req_valid, 1'b1);
        chk("target_req_addr", imem_req_addr, 32'h100);
        chk("target_if_valid", if_valid, 1'b0);
        repeat (3) next_cycle();
        #2;
        chk("target_if_valid_k8", if_valid, 1'b0);

        // Redirect to 0x203 alongside a response and a decode handshake
        next_cycle();
        chk("target_if_valid_k9", if_valid, 1'b1);
        chk("target_if_pc_k9", if_pc, 32'h100);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        exp_q.push_back(32'h200);
        next_cycle();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #2;
        chk("redir2_if_valid_k10", if_valid, 1'b0);
        chk("redir2_req_valid_k10", imem_req_valid, 1'b0);
        for (int k = 11; k <= 12; k++) begin
            next_cycle();
            #2;
            chk($sformatf("redir2_req_valid_k%0d", k), imem_req_valid, 1'b0);
        end
        next_cycle();
        #2;
        chk("redir2_req_valid_k13", imem_req_valid, 1'b1);
        chk("redir2_req_addr_k13", imem_req_addr, 32'h200);
        repeat (5) next_cycle();
        chk("redir2_if_valid_k18", if_valid, 1'b1);
        if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;
        repeat (3) next_cycle();

        // Asynchronous reset with a full FIFO
        chk("full_if_valid", if_valid, 1'b1);
        chk("full_if_pc", if_pc, 32'h204);
        chk("full_exp_empty", exp_q.size(), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_if_valid", if_valid, 1'b0);
        chk("async_req_valid", imem_req_valid, 1'b0);
        chk("async_if_pc", if_pc, 32'h0);
        chk("async_req_addr", imem_req_addr, 32'h0);
        lat = 1;
        next_cycle();
        next_cycle();

        // Restart at RESET_PC
        next_cycle();
        rst = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        #2;
        chk("restart_req_valid", imem_req_valid, 1'b1);
        chk("restart_req_addr", imem_req_addr, 32'h0);
        repeat (5) next_cycle();
        next_cycle();
        if_ready = 1'b0;
        repeat (2) next_cycle();
        #2;
        chk("restart_exp_empty", exp_q.size(), 32'd0);
        chk("hi_deliveries", idx2, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
